// File: rtl/coin_credit_accumulator.sv
// coin_credit_accumulator
//   Front end of the soda machine datapath. Collects coins into an unsigned
//   credit register. When the credit reaches PRICE it vends, and it returns
//   change or refunds through a valid/ack handshake.
//
//   n_bit_adder : unsigned WIDTH-bit adder with carry-in and carry-out (oflo).
//
//   Ports (coin_credit_accumulator):
//     clk          in   1      rising-edge clock
//     reset_n      in   1      synchronous reset, active-low
//     coin_valid   in   1      coin present this cycle
//     coin_type    in   2      00 nickel, 01 dime, 10 quarter, 11 invalid
//     cancel       in   1      refund request (level)
//     change_ack   in   1      consumer took change_amt
//     coin_ready   out  1      high only while collecting
//     coin_reject  out  1      1-cycle pulse: offered coin not credited
//     dispense     out  1      1-cycle vend pulse
//     change_valid out  1      change_amt valid, held until acked
//     change_amt   out  WIDTH  change/refund in cents
//     credit       out  WIDTH  current credit

module n_bit_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             oflo
);
  logic [WIDTH:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign sum  = full[WIDTH-1:0];
  assign oflo = full[WIDTH];
endmodule

// state      | meaning
// S_COLLECT  | accepting coins, cancel refunds any credit
// S_DISPENSE | one-cycle vend, computes change = credit - PRICE
// S_CHANGE   | change_amt presented, waiting for change_ack
module coin_credit_accumulator #(
  parameter int WIDTH   = 8,
  parameter int PRICE   = 75,
  parameter int NICKEL  = 5,
  parameter int DIME    = 10,
  parameter int QUARTER = 25
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             coin_valid,
  input  logic [1:0]       coin_type,
  input  logic             cancel,
  input  logic             change_ack,
  output logic             coin_ready,
  output logic             coin_reject,
  output logic             dispense,
  output logic             change_valid,
  output logic [WIDTH-1:0] change_amt,
  output logic [WIDTH-1:0] credit
);

  typedef enum logic [1:0] {
    S_COLLECT  = 2'd0,
    S_DISPENSE = 2'd1,
    S_CHANGE   = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] PRICE_W = WIDTH'(PRICE);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] credit_q, credit_d;
  logic [WIDTH-1:0] change_amt_q, change_amt_d;
  logic             coin_reject_q, coin_reject_d;
  logic             dispense_q, dispense_d;
  logic             change_valid_q, change_valid_d;
  logic             coin_ready_q, coin_ready_d;

  logic [WIDTH-1:0] coin_value;
  logic [WIDTH-1:0] add_sum;
  logic             add_oflo;
  logic [WIDTH-1:0] chg_diff;
  logic             chg_no_borrow;

  always_comb begin
    coin_value = '0;
    case (coin_type)
      2'b00:   coin_value = WIDTH'(NICKEL);
      2'b01:   coin_value = WIDTH'(DIME);
      2'b10:   coin_value = WIDTH'(QUARTER);
      default: coin_value = '0;
    endcase
  end

  n_bit_adder #(.WIDTH(WIDTH)) u_credit_add (
    .a    (credit_q),
    .b    (coin_value),
    .cin  (1'b0),
    .sum  (add_sum),
    .oflo (add_oflo)
  );

  // credit - PRICE as credit + ~PRICE + 1; carry-out set means no borrow
  n_bit_adder #(.WIDTH(WIDTH)) u_change_sub (
    .a    (credit_q),
    .b    (~PRICE_W),
    .cin  (1'b1),
    .sum  (chg_diff),
    .oflo (chg_no_borrow)
  );

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    change_amt_d  = change_amt_q;
    coin_reject_d = 1'b0;

    case (state_q)
      S_COLLECT: begin
        if (cancel) begin
          coin_reject_d = coin_valid;
          if (credit_q != '0) begin
            change_amt_d = credit_q;
            credit_d     = '0;
            state_d      = S_CHANGE;
          end
        end else if (coin_valid) begin
          if (coin_type == 2'b11 || add_oflo) begin
            coin_reject_d = 1'b1;
          end else begin
            credit_d = add_sum;
            if (add_sum >= PRICE_W) state_d = S_DISPENSE;
          end
        end
      end

      S_DISPENSE: begin
        // credit >= PRICE on entry, so a borrow cannot occur; guard anyway
        change_amt_d = chg_no_borrow ? chg_diff : '0;
        credit_d     = '0;
        state_d      = (chg_no_borrow && chg_diff != '0) ? S_CHANGE : S_COLLECT;
      end

      S_CHANGE: begin
        if (change_ack) begin
          change_amt_d = '0;
          state_d      = S_COLLECT;
        end
      end

      default: state_d = S_COLLECT;
    endcase

    // status outputs are registered off the next state
    dispense_d     = (state_d == S_DISPENSE);
    change_valid_d = (state_d == S_CHANGE);
    coin_ready_d   = (state_d == S_COLLECT);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= S_COLLECT;
      credit_q       <= '0;
      change_amt_q   <= '0;
      coin_reject_q  <= 1'b0;
      dispense_q     <= 1'b0;
      change_valid_q <= 1'b0;
      coin_ready_q   <= 1'b1;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      change_amt_q   <= change_amt_d;
      coin_reject_q  <= coin_reject_d;
      dispense_q     <= dispense_d;
      change_valid_q <= change_valid_d;
      coin_ready_q   <= coin_ready_d;
    end
  end

  assign coin_ready   = coin_ready_q;
  assign coin_reject  = coin_reject_q;
  assign dispense     = dispense_q;
  assign change_valid = change_valid_q;
  assign change_amt   = change_amt_q;
  assign credit       = credit_q;

endmodule

// File: tb/tb_coin_credit_accumulator.sv
module tb_coin_credit_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;

  // default instance: WIDTH=8, PRICE=75
  logic       cv, can, ack;
  logic [1:0] ct;
  logic       rdy, rej, disp, cvld;
  logic [7:0] camt, cred;

  // narrow instance: WIDTH=5, PRICE=31
  logic       cv2, can2, ack2;
  logic [1:0] ct2;
  logic       rdy2, rej2, disp2, cvld2;
  logic [4:0] camt2, cred2;

  coin_credit_accumulator dut (
    .clk(clk), .reset_n(reset_n), .coin_valid(cv), .coin_type(ct),
    .cancel(can), .change_ack(ack), .coin_ready(rdy), .coin_reject(rej),
    .dispense(disp), .change_valid(cvld), .change_amt(camt), .credit(cred)
  );

  coin_credit_accumulator #(.WIDTH(5), .PRICE(31)) dut_narrow (
    .clk(clk), .reset_n(reset_n), .coin_valid(cv2), .coin_type(ct2),
    .cancel(can2), .change_ack(ack2), .coin_ready(rdy2), .coin_reject(rej2),
    .dispense(disp2), .change_valid(cvld2), .change_amt(camt2), .credit(cred2)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic       cv;
    logic [1:0] ct;
    logic       can;
    logic       ack;
    int         credit;
    logic       disp;
    logic       cvld;
    int         camt;
    logic       rdy;
    logic       rej;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [1:0] t, logic c, logic a,
                              int cr, logic d, logic vl, int amt, logic r, logic j);
    vec_t x;
    x.cv = v; x.ct = t; x.can = c; x.ack = a;
    x.credit = cr; x.disp = d; x.cvld = vl; x.camt = amt; x.rdy = r; x.rej = j;
    return x;
  endfunction

  task automatic check(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_all(string tag, int cr, int d, int vl, int amt, int r, int j);
    check({tag, " credit"},       int'(cred), cr);
    check({tag, " dispense"},     int'(disp), d);
    check({tag, " change_valid"}, int'(cvld), vl);
    check({tag, " change_amt"},   int'(camt), amt);
    check({tag, " coin_ready"},   int'(rdy),  r);
    check({tag, " coin_reject"},  int'(rej),  j);
  endtask

  task automatic step(logic v, logic [1:0] t, logic c, logic a);
    @(negedge clk);
    cv = v; ct = t; can = c; ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic step2(logic v, logic [1:0] t, logic c);
    @(negedge clk);
    cv2 = v; ct2 = t; can2 = c;
    @(posedge clk);
    #1;
  endtask

  localparam logic [1:0] N = 2'b00, D = 2'b01, Q = 2'b10, X = 2'b11;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    cv = 0; ct = N; can = 0; ack = 0;
    cv2 = 0; ct2 = N; can2 = 0; ack2 = 0;

    // T2: three quarters
    vecs.push_back(mk(1, Q, 0, 0, 25, 0, 0, 0,  1, 0));
    vecs.push_back(mk(1, Q, 0, 0, 50, 0, 0, 0,  1, 0));
    vecs.push_back(mk(1, Q, 0, 0, 75, 1, 0, 0,  0, 0));
    vecs.push_back(mk(0, N, 0, 0, 0,  0, 0, 0,  1, 0));
    vecs.push_back(mk(0, N, 0, 1, 0,  0, 0, 0,  1, 0)); // ack outside S_CHANGE
    // T3: Q,Q,D,Q -> change 10 held, coin_valid ignored while waiting
    vecs.push_back(mk(1, Q, 0, 0, 25, 0, 0, 0,  1, 0));
    vecs.push_back(mk(1, Q, 0, 0, 50, 0, 0, 0,  1, 0));
    vecs.push_back(mk(1, D, 0, 0, 60, 0, 0, 0,  1, 0));
    vecs.push_back(mk(1, Q, 0, 0, 85, 1, 0, 0,  0, 0));
    vecs.push_back(mk(0, N, 0, 0, 0,  0, 1, 10, 0, 0));
    vecs.push_back(mk(0, N, 0, 0, 0,  0, 1, 10, 0, 0));
    vecs.push_back(mk(1, Q, 0, 0, 0,  0, 1, 10, 0, 0));
    vecs.push_back(mk(1, X, 0, 0, 0,  0, 1, 10, 0, 0));
    vecs.push_back(mk(0, N, 0, 0, 0,  0, 1, 10, 0, 0));
    vecs.push_back(mk(0, N, 0, 1, 0,  0, 0, 0,  1, 0));
    // T6: coin_valid held through S_DISPENSE
    vecs.push_back(mk(1, Q, 0, 0, 25, 0, 0, 0,  1, 0));
    vecs.push_back(mk(1, Q, 0, 0, 50, 0, 0, 0,  1, 0));
    vecs.push_back(mk(1, Q, 0, 0, 75, 1, 0, 0,  0, 0));
    vecs.push_back(mk(1, Q, 0, 0, 0,  0, 0, 0,  1, 0));
    vecs.push_back(mk(1, Q, 0, 0, 25, 0, 0, 0,  1, 0));
    // T4: cancel refunds
    vecs.push_back(mk(0, N, 1, 0, 0,  0, 1, 25, 0, 0));
    vecs.push_back(mk(0, N, 0, 1, 0,  0, 0, 0,  1, 0));
    vecs.push_back(mk(1, D, 0, 0, 10, 0, 0, 0,  1, 0));
    vecs.push_back(mk(1, N, 0, 0, 15, 0, 0, 0,  1, 0));
    vecs.push_back(mk(0, N, 1, 0, 0,  0, 1, 15, 0, 0));
    vecs.push_back(mk(1, Q, 0, 1, 0,  0, 0, 0,  1, 0));
    vecs.push_back(mk(1, Q, 1, 0, 0,  0, 0, 0,  1, 1)); // cancel, no credit
    vecs.push_back(mk(0, N, 0, 0, 0,  0, 0, 0,  1, 0));
    vecs.push_back(mk(1, X, 0, 0, 0,  0, 0, 0,  1, 1)); // invalid coin
    vecs.push_back(mk(1, D, 0, 0, 10, 0, 0, 0,  1, 0));
    vecs.push_back(mk(1, Q, 1, 0, 0,  0, 1, 10, 0, 1)); // cancel + quarter
    vecs.push_back(mk(0, N, 0, 1, 0,  0, 0, 0,  1, 0));
    // overshoot: 70 + 25 = 95 -> change 20
    vecs.push_back(mk(1, Q, 0, 0, 25, 0, 0, 0,  1, 0));
    vecs.push_back(mk(1, Q, 0, 0, 50, 0, 0, 0,  1, 0));
    vecs.push_back(mk(1, D, 0, 0, 60, 0, 0, 0,  1, 0));
    vecs.push_back(mk(1, D, 0, 0, 70, 0, 0, 0,  1, 0));
    vecs.push_back(mk(1, Q, 0, 0, 95, 1, 0, 0,  0, 0));
    vecs.push_back(mk(0, N, 0, 0, 0,  0, 1, 20, 0, 0));
    vecs.push_back(mk(0, N, 0, 1, 0,  0, 0, 0,  1, 0));

    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 0, 0, 1, 0);
    check("reset narrow credit", int'(cred2), 0);
    check("reset narrow coin_ready", int'(rdy2), 1);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].cv, vecs[i].ct, vecs[i].can, vecs[i].ack);
      check_all($sformatf("row%0d", i), vecs[i].credit, int'(vecs[i].disp),
                int'(vecs[i].cvld), vecs[i].camt, int'(vecs[i].rdy), int'(vecs[i].rej));
    end

    // T1: reset held 2 cycles while waiting in S_CHANGE
    step(1, D, 0, 0);
    step(0, N, 1, 0);
    check_all("t1 pre", 0, 0, 1, 10, 0, 0);
    @(negedge clk);
    reset_n = 1'b0; cv = 1; ct = Q;
    @(posedge clk); #1;
    check_all("t1 rst1", 0, 0, 0, 0, 1, 0);
    @(posedge clk); #1;
    check_all("t1 rst2", 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    reset_n = 1'b1; cv = 0;
    step(0, N, 0, 1);
    check_all("t1 post", 0, 0, 0, 0, 1, 0);
    step(1, Q, 0, 0);
    check_all("t1 coin", 25, 0, 0, 0, 1, 0);

    // T5: WIDTH=5, PRICE=31 overflow handling
    step2(1, Q, 0);
    check("t5 q credit", int'(cred2), 25);
    check("t5 q reject", int'(rej2), 0);
    step2(1, D, 0);
    check("t5 oflo credit", int'(cred2), 25);
    check("t5 oflo reject", int'(rej2), 1);
    step2(1, N, 0);
    check("t5 n credit", int'(cred2), 30);
    check("t5 n reject", int'(rej2), 0);
    step2(1, N, 0);
    check("t5 oflo2 credit", int'(cred2), 30);
    check("t5 oflo2 reject", int'(rej2), 1);
    check("t5 oflo2 dispense", int'(disp2), 0);
    step2(1, X, 0);
    check("t5 invalid credit", int'(cred2), 30);
    check("t5 invalid reject", int'(rej2), 1);
    step2(0, N, 1);
    check("t5 cancel reject", int'(rej2), 0);
    check("t5 cancel change_amt", int'(camt2), 30);
    check("t5 cancel change_valid", int'(cvld2), 1);
    check("t5 cancel credit", int'(cred2), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
